vx_mem_responder: RTL and testbench



---
 rtl/vx_mem_responder.sv | 153 +++++++++++++++
 tb/tb_vx_mem_responder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_responder.sv
// Memory-side responder: byte-enabled word RAM with a fixed-latency, in-order read pipeline
// and a credit-bounded response FIFO so responses are never dropped under backpressure.
module vx_mem_responder #(
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic                    mem_req_rw,
  input  logic [DATA_WIDTH/8-1:0] mem_req_byteen,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready
);

  localparam int          ByteW = int'(DATA_WIDTH / 8);
  localparam int unsigned Words = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW  = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PtrW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("LATENCY must be >= 1");
  end
  if (RSP_DEPTH < 1) begin : g_bad_rsp_depth
    $error("RSP_DEPTH must be >= 1");
  end

  logic                  req_fire, read_fire, write_fire, rsp_fire;
  logic [CntW-1:0]       pending_q, pending_d;
  logic [DATA_WIDTH-1:0] ram [Words];
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic [TAG_WIDTH-1:0]  push_tag;
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [RSP_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(RSP_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Credits cover both pipeline and FIFO occupancy, so the FIFO can never overflow.
  assign mem_req_ready = ~reset & (pending_q < CntW'(RSP_DEPTH));
  assign req_fire      = mem_req_valid & mem_req_ready;
  assign read_fire     = req_fire & ~mem_req_rw;
  assign write_fire    = req_fire & mem_req_rw;
  assign mem_rsp_valid = ~reset & (count_q != '0);
  assign rsp_fire      = mem_rsp_valid & mem_rsp_ready;

  always_comb begin
    pending_d = pending_q;
    case ({read_fire, rsp_fire})
      2'b10:   pending_d = pending_q + CntW'(1);
      2'b01:   pending_d = pending_q - CntW'(1);
      default: pending_d = pending_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // RAM is deliberately not reset; contents persist across reset.
  always_ff @(posedge clk) begin
    if (write_fire) begin
      for (int i = 0; i < ByteW; i++) begin
        if (mem_req_byteen[i]) ram[mem_req_addr][i*8 +: 8] <= mem_req_data[i*8 +: 8];
      end
    end
  end

  assign ram_rdata = ram[mem_req_addr];

  // The FIFO register itself provides the last cycle of latency.
  if (LATENCY > 1) begin : g_pipe
    logic [LATENCY-2:0]    vld_q;
    logic [DATA_WIDTH-1:0] dat_q [LATENCY-1];
    logic [TAG_WIDTH-1:0]  tag_q [LATENCY-1];

    always_ff @(posedge clk) begin
      if (reset) begin
        vld_q <= '0;
      end else begin
        vld_q[0] <= read_fire;
        for (int i = 1; i < int'(LATENCY) - 1; i++) vld_q[i] <= vld_q[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_q[0] <= ram_rdata;
      tag_q[0] <= mem_req_tag;
      for (int i = 1; i < int'(LATENCY) - 1; i++) begin
        dat_q[i] <= dat_q[i-1];
        tag_q[i] <= tag_q[i-1];
      end
    end

    assign push_valid = vld_q[LATENCY-2];
    assign push_data  = dat_q[LATENCY-2];
    assign push_tag   = tag_q[LATENCY-2];
  end else begin : g_no_pipe
    assign push_valid = read_fire;
    assign push_data  = ram_rdata;
    assign push_tag   = mem_req_tag;
  end

  always_comb begin
    count_d = count_q;
    case ({push_valid, rsp_fire})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_valid) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rsp_fire)   rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_valid) begin
      fifo_data[wr_ptr_q] <= push_data;
      fifo_tag[wr_ptr_q]  <= push_tag;
    end
  end

  assign mem_rsp_data = fifo_data[rd_ptr_q];
  assign mem_rsp_tag  = fifo_tag[rd_ptr_q];

endmodule

// File: tb/tb_vx_mem_responder.sv
// Scoreboard bench for vx_mem_responder: a word-array memory model predicts read data, ordering,
// latency and credit-based ready; a negedge monitor checks the DUT against it.
module tb_vx_mem_responder;
  localparam int DW = 512, AW = 6, TW = 8, LAT = 2, DEPTH = 4;
  localparam int BW = DW / 8, WORDS = 2 ** AW;

  logic          clk = 1'b0, reset = 1'b1;
  logic          mem_req_valid = 1'b0, mem_req_rw = 1'b0, mem_req_ready;
  logic [AW-1:0] mem_req_addr = '0;
  logic [BW-1:0] mem_req_byteen = '0;
  logic [DW-1:0] mem_req_data = '0;
  logic [TW-1:0] mem_req_tag = '0;
  logic          mem_rsp_valid, mem_rsp_ready;
  logic [DW-1:0] mem_rsp_data;
  logic [TW-1:0] mem_rsp_tag;

  vx_mem_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .LATENCY(LAT), .RSP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    int            issue;
  } exp_t;

  exp_t          q[$];
  logic [DW-1:0] mdl [WORDS];
  int            checks = 0, fails = 0, cyc = 0, stalls = 0, rdy_mode = 1, last_pop = 0;
  bit            head_seen = 1'b0;

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    mem_rsp_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       mem_rsp_ready = 1'b0;
        1:       mem_rsp_ready = 1'b1;
        default: mem_rsp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Issue one request, waiting (bounded) for ready; the model is updated at the fire.
  task automatic req(input bit rw, input int addr, input logic [BW-1:0] be,
                     input logic [DW-1:0] data, input logic [TW-1:0] tag);
    int   budget = 200;
    exp_t e;
    @(negedge clk);
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = AW'(addr);
    mem_req_byteen = be; mem_req_data = data; mem_req_tag = tag;
    #1;
    while (!mem_req_ready && budget > 0) begin
      stalls++; budget--;
      @(negedge clk);
      #1;
    end
    if (!mem_req_ready) begin
      checks++; fails++;
      $display("FAIL req_timeout: got ready=0 for 200 cycles want 1");
      mem_req_valid = 1'b0;
      return;
    end
    if (rw) begin
      for (int i = 0; i < BW; i++) if (be[i]) mdl[addr][i*8 +: 8] = data[i*8 +: 8];
    end else begin
      e.data = mdl[addr]; e.tag = tag; e.issue = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1 mem_req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget = 1000;
    while (q.size() != 0 && budget > 0) begin @(negedge clk); budget--; end
    if (q.size() != 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic sync_rdy(input int mode);
    rdy_mode = mode;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    #1 reset = 1'b0;
    q.delete(); head_seen = 1'b0; last_pop = cyc;
  endtask

  // Monitor: ready vs credits, head data/tag vs scoreboard, first-valid latency.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      chk("reset_rsp_valid", DW'(mem_rsp_valid), '0);
      chk("reset_req_ready", DW'(mem_req_ready), '0);
    end else begin
      chk("req_ready", DW'(mem_req_ready), DW'(q.size() < DEPTH));
      if (mem_rsp_valid) begin
        if (q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_rsp: got mem_rsp_valid=1 tag %h want 0", mem_rsp_tag);
        end else begin
          chk("rsp_tag", DW'(mem_rsp_tag), DW'(q[0].tag));
          chk("rsp_data", mem_rsp_data, q[0].data);
          if (!head_seen) begin
            int exp_c;
            exp_c = (q[0].issue + LAT > last_pop + 1) ? q[0].issue + LAT : last_pop + 1;
            chk("rsp_latency", DW'(cyc), DW'(exp_c));
            head_seen = 1'b1;
          end
          if (mem_rsp_ready) begin
            void'(q.pop_front());
            head_seen = 1'b0;
            last_pop = cyc;
          end
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    last_pop = cyc;

    for (int a = 0; a < WORDS; a++) req(1'b1, a, '1, rand_word(), '0);

    // Full write then read with latency check
    req(1'b1, 5, '1, {BW{8'hA5}}, '0);
    req(1'b0, 5, '0, '0, 8'h3C);
    wait_drain();

    // Partial write keeps unselected bytes
    req(1'b1, 3, '1, {BW{8'h11}}, '0);
    req(1'b1, 3, BW'(1), {BW{8'hFF}}, '0);
    req(1'b0, 3, '0, '0, 8'h01);
    wait_drain();

    // Back-to-back streaming never stalls
    stalls = 0;
    for (int i = 0; i < 8; i++) req(1'b0, i, '0, '0, 8'(i));
    chk("stream_no_stall", DW'(stalls), '0);
    wait_drain();

    // Backpressure: credits exhaust after DEPTH reads, head holds
    sync_rdy(0);
    for (int i = 0; i < DEPTH; i++) req(1'b0, 10 + i, '0, '0, 8'(8'h40 + i));
    @(negedge clk);
    #1 chk("bp_ready_low", DW'(mem_req_ready), '0);
    repeat (3) @(negedge clk);
    rdy_mode = 1;
    req(1'b0, 20, '0, '0, 8'h50);
    wait_drain();

    // Reset mid-flight drops responses, RAM persists
    sync_rdy(0);
    for (int i = 0; i < 3; i++) req(1'b0, 30 + i, '0, '0, 8'(8'h60 + i));
    do_reset();
    @(negedge clk);
    #1;
    chk("post_reset_ready", DW'(mem_req_ready), DW'(1));
    chk("post_reset_valid", DW'(mem_rsp_valid), '0);
    rdy_mode = 1;
    req(1'b0, 5, '0, '0, 8'h77);
    wait_drain();

    // Write then read in the next cycle
    req(1'b1, 9, '1, {BW{8'h5A}}, '0);
    req(1'b0, 9, '0, '0, 8'h99);
    wait_drain();

    // Random mix with random response backpressure
    rdy_mode = 2;
    for (int n = 0; n < 400; n++) begin
      logic [BW-1:0] be;
      be = {$urandom, $urandom};
      req(1'($urandom_range(0, 1)), int'($urandom_range(0, WORDS - 1)), be, rand_word(),
          8'($urandom));
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    rdy_mode = 1;
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
